cp0_count_compare: RTL and testbench

//  CP0 Count/Compare timer pair. Holds Count (free-running, advanced by tick) and Compare (software set),

---
 rtl/cp0_count_compare_pkg.sv | 20 ++
 rtl/cp0_count_compare_tick_gen.sv | 39 +++
 rtl/cp0_count_compare.sv | 112 +++++++++++
 tb/tb_cp0_count_compare.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_count_compare_pkg.sv
// Shared CP0 definitions for the Count/Compare timer slice: cp0addr encoding
// ({reg[4:0], sel[1:0]}, common with Cause/Status), reset defaults and widths.
package cp0_count_compare_pkg;

    localparam int unsigned CP0_ADDR_W = 7;
    localparam int unsigned CNT_W_DEF  = 32;

    // Builds a cp0addr from register number and select.
    function automatic logic [CP0_ADDR_W-1:0] cp0addr(input logic [4:0] reg_num,
                                                      input logic [1:0] sel);
        return {reg_num, sel};
    endfunction

    localparam logic [CP0_ADDR_W-1:0] CP0ADDR_COUNT   = {5'd9,  2'd0};
    localparam logic [CP0_ADDR_W-1:0] CP0ADDR_COMPARE = {5'd11, 2'd0};

    localparam logic [CNT_W_DEF-1:0] COUNT_INI   = '0;
    localparam logic [CNT_W_DEF-1:0] COMPARE_INI = '0;

endpackage

// File: rtl/cp0_count_compare_tick_gen.sv
// Count advance enable generator.
// Macro CP0_COUNT_DIV2_EN: defined -> tick every second cycle (phase register,
// tick while phase==1, cleared by a Count write); undefined -> tick every cycle.
// Ports: clk, rst_n (sync, active-low), clr_i (Count write), tick_o (advance enable).
module cp0_tick_gen (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic tick_o
);

`ifdef CP0_COUNT_DIV2_EN
    logic phase_q;
    logic phase_d;

    // Phase toggles every cycle; a Count write restarts it so the next tick is 2 cycles out.
    always_comb begin
        phase_d = ~phase_q;
        if (clr_i) begin
            phase_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign tick_o = phase_q;
`else
    logic unused_c;
    assign unused_c = ^{clk, rst_n, clr_i};
    assign tick_o   = 1'b1;
`endif

endmodule

// File: rtl/cp0_count_compare.sv
// CP0 Count/Compare timer pair with sticky timer interrupt and registered mfc0 reads.
// Optional half-rate Count via macro CP0_COUNT_DIV2_EN (handled in cp0_tick_gen).
// Ports: clk, rst_n (sync, active-low); mtc0_we/cp0_addr/mtc0_data write port;
// mfc0_re/rd_addr read request; cp0_rdata/rd_hit registered read response (latency 1);
// ti timer-interrupt level to Cause.TI.
module cp0_count_compare
    import cp0_count_compare_pkg::*;
#(
    parameter int unsigned       CNT_W       = CNT_W_DEF,
    parameter logic [CNT_W-1:0]  COUNT_RST   = CNT_W'(COUNT_INI),
    parameter logic [CNT_W-1:0]  COMPARE_RST = CNT_W'(COMPARE_INI)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mtc0_we,
    input  logic [CP0_ADDR_W-1:0] cp0_addr,
    input  logic [CNT_W-1:0]      mtc0_data,
    input  logic                  mfc0_re,
    input  logic [CP0_ADDR_W-1:0] rd_addr,
    output logic [CNT_W-1:0]      cp0_rdata,
    output logic                  rd_hit,
    output logic                  ti
);

    logic             tick;
    logic             count_we;
    logic             compare_we;
    logic             match;
    logic [CNT_W-1:0] count_inc;

    logic [CNT_W-1:0] count_q,   count_d;
    logic [CNT_W-1:0] compare_q, compare_d;
    logic             ti_q,      ti_d;
    logic [CNT_W-1:0] rdata_q,   rdata_d;
    logic             rd_hit_q,  rd_hit_d;

    assign count_we   = mtc0_we && (cp0_addr == CP0ADDR_COUNT);
    assign compare_we = mtc0_we && (cp0_addr == CP0ADDR_COMPARE);

    cp0_tick_gen u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (count_we),
        .tick_o (tick)
    );

    // Match looks ahead at the value Count is about to take, so ti rises on the same
    // edge Count lands on Compare; a software Count write never produces a match.
    assign count_inc = count_q + CNT_W'(1);
    assign match     = tick && !count_we && (count_inc == compare_q);

    // Next-state: Count/Compare update, sticky ti, read-before-write response.
    always_comb begin
        count_d   = count_q;
        compare_d = compare_q;
        ti_d      = ti_q;
        rdata_d   = rdata_q;
        rd_hit_d  = rd_hit_q;

        if (count_we) begin
            count_d = mtc0_data;
        end else if (tick) begin
            count_d = count_inc;
        end

        // Compare write beats a coincident match.
        if (compare_we) begin
            compare_d = mtc0_data;
            ti_d      = 1'b0;
        end else if (match) begin
            ti_d = 1'b1;
        end

        if (mfc0_re) begin
            case (rd_addr)
                CP0ADDR_COUNT: begin
                    rdata_d  = count_q;
                    rd_hit_d = 1'b1;
                end
                CP0ADDR_COMPARE: begin
                    rdata_d  = compare_q;
                    rd_hit_d = 1'b1;
                end
                default: begin
                    rdata_d  = '0;
                    rd_hit_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q   <= COUNT_RST;
            compare_q <= COMPARE_RST;
            ti_q      <= 1'b0;
            rdata_q   <= '0;
            rd_hit_q  <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
            rdata_q   <= rdata_d;
            rd_hit_q  <= rd_hit_d;
        end
    end

    assign cp0_rdata = rdata_q;
    assign rd_hit    = rd_hit_q;
    assign ti        = ti_q;

endmodule

// File: tb/tb_cp0_count_compare.sv
// Bench for cp0_count_compare: directed scenarios plus a randomized run against a
// cycle-level behavioural model of the Count/Compare rules.
module tb_cp0_count_compare;
    import cp0_count_compare_pkg::*;

    localparam int unsigned W = 32;
`ifdef CP0_COUNT_DIV2_EN
    localparam int PER = 2;
`else
    localparam int PER = 1;
`endif

    logic                  clk;
    logic                  rst_n;
    logic                  mtc0_we;
    logic [CP0_ADDR_W-1:0] cp0_addr;
    logic [W-1:0]          mtc0_data;
    logic                  mfc0_re;
    logic [CP0_ADDR_W-1:0] rd_addr;
    logic [W-1:0]          cp0_rdata;
    logic                  rd_hit;
    logic                  ti;

    int total;
    int bad;

    cp0_count_compare #(
        .CNT_W       (W),
        .COUNT_RST   (32'd0),
        .COMPARE_RST (32'd5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mtc0_we   (mtc0_we),
        .cp0_addr  (cp0_addr),
        .mtc0_data (mtc0_data),
        .mfc0_re   (mfc0_re),
        .rd_addr   (rd_addr),
        .cp0_rdata (cp0_rdata),
        .rd_hit    (rd_hit),
        .ti        (ti)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: architectural registers plus the half-rate phase.
    logic [W-1:0] m_count, m_compare, m_rdata, m_next;
    logic         m_ti, m_hit, m_phase, m_tick, m_cw, m_pw, m_match;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_count = 32'd0; m_compare = 32'd5; m_ti = 1'b0;
            m_phase = 1'b0;  m_rdata = 32'd0;   m_hit = 1'b0;
        end else begin
            m_tick  = (PER == 1) ? 1'b1 : m_phase;
            m_cw    = mtc0_we && (cp0_addr == CP0ADDR_COUNT);
            m_pw    = mtc0_we && (cp0_addr == CP0ADDR_COMPARE);
            if (mfc0_re) begin
                if (rd_addr == CP0ADDR_COUNT) begin m_rdata = m_count; m_hit = 1'b1; end
                else if (rd_addr == CP0ADDR_COMPARE) begin m_rdata = m_compare; m_hit = 1'b1; end
                else begin m_rdata = 32'd0; m_hit = 1'b0; end
            end
            m_next  = m_count + 32'd1;
            m_match = m_tick && !m_cw && (m_next == m_compare);
            if (m_pw) m_ti = 1'b0;
            else if (m_match) m_ti = 1'b1;
            if (m_pw) m_compare = mtc0_data;
            if (m_cw) m_count = mtc0_data;
            else if (m_tick) m_count = m_next;
            m_phase = m_cw ? 1'b0 : ~m_phase;
        end
    end

    task automatic clk_step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [CP0_ADDR_W-1:0] a, input logic [W-1:0] d);
        mtc0_we = 1'b1; cp0_addr = a; mtc0_data = d;
        clk_step(1);
        mtc0_we = 1'b0;
    endtask

    task automatic rd(input logic [CP0_ADDR_W-1:0] a);
        mfc0_re = 1'b1; rd_addr = a;
        clk_step(1);
        mfc0_re = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clk_step(3);
        total++; if (ti !== 1'b0) begin bad++; $display("FAIL reset_ti got=%0h exp=0", ti); end
        total++; if (cp0_rdata !== 32'd0) begin bad++; $display("FAIL reset_rdata got=%0h exp=0", cp0_rdata); end
        total++; if (rd_hit !== 1'b0) begin bad++; $display("FAIL reset_hit got=%0h exp=0", rd_hit); end
    endtask

    // Compare=5 from reset: ti rises on the edge Count reaches 5, then stays.
    task automatic test_first_match();
        logic exp;
        rst_n = 1'b1;
        for (int i = 1; i <= 5 * PER + 3; i++) begin
            clk_step(1);
            exp = (i >= 5 * PER);
            total++; if (ti !== exp) begin bad++; $display("FAIL first_match_ti cyc=%0d got=%0h exp=%0h", i, ti, exp); end
        end
        rd(CP0ADDR_COMPARE);
        total++; if (cp0_rdata !== 32'd5 || rd_hit !== 1'b1) begin
            bad++; $display("FAIL read_compare_rst got=%0h/%0h exp=5/1", cp0_rdata, rd_hit); end
    endtask

    task automatic test_compare_rewrite();
        int n;
        wr(CP0ADDR_COMPARE, 32'd20);
        total++; if (ti !== 1'b0) begin bad++; $display("FAIL cmp_write_clears_ti got=%0h exp=0", ti); end
        n = 0;
        while (ti !== 1'b1 && n < 100) begin clk_step(1); n++; end
        total++; if (ti !== 1'b1) begin bad++; $display("FAIL cmp20_ti_timeout got=%0h exp=1", ti); end
        rd(CP0ADDR_COUNT);
        total++; if (cp0_rdata !== 32'd20) begin bad++; $display("FAIL cmp20_count got=%0h exp=14", cp0_rdata); end
    endtask

    task automatic test_wrap();
        logic exp;
        wr(CP0ADDR_COMPARE, 32'd0);
        wr(CP0ADDR_COUNT, 32'hFFFF_FFFE);
        for (int i = 1; i <= 2 * PER; i++) begin
            clk_step(1);
            exp = (i == 2 * PER);
            total++; if (ti !== exp) begin bad++; $display("FAIL wrap_ti cyc=%0d got=%0h exp=%0h", i, ti, exp); end
        end
        rd(CP0ADDR_COUNT);
        total++; if (cp0_rdata !== 32'd0) begin bad++; $display("FAIL wrap_count got=%0h exp=0", cp0_rdata); end
    endtask

    task automatic test_count_eq_compare();
        wr(CP0ADDR_COMPARE, 32'h40);
        wr(CP0ADDR_COUNT, 32'h40);
        for (int i = 0; i < 4; i++) begin
            clk_step(1);
            total++; if (ti !== 1'b0) begin bad++; $display("FAIL count_eq_cmp_ti cyc=%0d got=%0h exp=0", i, ti); end
        end
    endtask

    task automatic test_simul_match_write();
        wr(CP0ADDR_COMPARE, 32'h50);
        wr(CP0ADDR_COUNT, 32'h4F);
        clk_step(PER - 1);
        wr(CP0ADDR_COMPARE, 32'h100);
        total++; if (ti !== 1'b0) begin bad++; $display("FAIL simul_ti got=%0h exp=0", ti); end
        clk_step(2);
        total++; if (ti !== 1'b0) begin bad++; $display("FAIL simul_ti_later got=%0h exp=0", ti); end
        rd(CP0ADDR_COMPARE);
        total++; if (cp0_rdata !== 32'h100 || rd_hit !== 1'b1) begin
            bad++; $display("FAIL simul_compare got=%0h/%0h exp=100/1", cp0_rdata, rd_hit); end
    endtask

    task automatic test_read_rw();
        logic [W-1:0] exp;
        wr(CP0ADDR_COUNT, 32'h30);
        mfc0_re = 1'b1; rd_addr = CP0ADDR_COUNT;
        wr(CP0ADDR_COUNT, 32'h55);
        mfc0_re = 1'b0;
        total++; if (cp0_rdata !== 32'h30 || rd_hit !== 1'b1) begin
            bad++; $display("FAIL rbw_count got=%0h/%0h exp=30/1", cp0_rdata, rd_hit); end
        clk_step(4);
        rd(CP0ADDR_COUNT);
        exp = 32'h55 + 32'(4 / PER);
        total++; if (cp0_rdata !== exp) begin bad++; $display("FAIL count_after_write got=%0h exp=%0h", cp0_rdata, exp); end
        rd(7'd0);
        total++; if (cp0_rdata !== 32'd0 || rd_hit !== 1'b0) begin
            bad++; $display("FAIL other_addr got=%0h/%0h exp=0/0", cp0_rdata, rd_hit); end
        rd(CP0ADDR_COMPARE);
        clk_step(3);
        total++; if (cp0_rdata !== 32'h100 || rd_hit !== 1'b1) begin
            bad++; $display("FAIL read_hold got=%0h/%0h exp=100/1", cp0_rdata, rd_hit); end
    endtask

    task automatic test_reset_mid();
        int n;
        wr(CP0ADDR_COUNT, 32'h10);
        wr(CP0ADDR_COMPARE, 32'h14);
        rd(CP0ADDR_COUNT);
        n = 0;
        while (ti !== 1'b1 && n < 40) begin clk_step(1); n++; end
        total++; if (ti !== 1'b1) begin bad++; $display("FAIL pre_reset_ti got=%0h exp=1", ti); end
        rst_n = 1'b0;
        clk_step(1);
        total++; if (ti !== 1'b0 || cp0_rdata !== 32'd0 || rd_hit !== 1'b0) begin
            bad++; $display("FAIL mid_reset got=%0h/%0h/%0h exp=0/0/0", ti, cp0_rdata, rd_hit); end
        rst_n = 1'b1;
        rd(CP0ADDR_COUNT);
        total++; if (cp0_rdata !== 32'd0 || rd_hit !== 1'b1) begin
            bad++; $display("FAIL post_reset_count got=%0h/%0h exp=0/1", cp0_rdata, rd_hit); end
    endtask

    task automatic test_random();
        int unsigned op;
        for (int i = 0; i < 600; i++) begin
            op = $urandom_range(0, 99);
            rst_n = (op != 0);
            mtc0_we = 1'b0; mfc0_re = 1'b0;
            if (op < 12) begin
                mtc0_we = 1'b1; cp0_addr = CP0ADDR_COUNT;
                mtc0_data = m_compare - 32'($urandom_range(0, 6));
            end else if (op < 20) begin
                mtc0_we = 1'b1; cp0_addr = CP0ADDR_COMPARE;
                mtc0_data = m_count + 32'($urandom_range(0, 8));
            end else if (op < 24) begin
                mtc0_we = 1'b1; cp0_addr = 7'($urandom_range(0, 127)); mtc0_data = $urandom;
            end
            if ($urandom_range(0, 2) == 0) begin
                mfc0_re = 1'b1;
                case ($urandom_range(0, 2))
                    0: rd_addr = CP0ADDR_COUNT;
                    1: rd_addr = CP0ADDR_COMPARE;
                    default: rd_addr = 7'($urandom_range(0, 127));
                endcase
            end
            clk_step(1);
            total++; if (ti !== m_ti || cp0_rdata !== m_rdata || rd_hit !== m_hit) begin
                bad++;
                $display("FAIL random cyc=%0d got ti=%0h rdata=%0h hit=%0h exp ti=%0h rdata=%0h hit=%0h",
                         i, ti, cp0_rdata, rd_hit, m_ti, m_rdata, m_hit);
            end
        end
        rst_n = 1'b1; mtc0_we = 1'b0; mfc0_re = 1'b0;
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; mtc0_we = 1'b0; cp0_addr = '0; mtc0_data = '0;
        mfc0_re = 1'b0; rd_addr = '0;
        test_reset();
        test_first_match();
        test_compare_rewrite();
        test_wrap();
        test_count_eq_compare();
        test_simul_match_write();
        test_read_rw();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
